// File: rtl/t_latch_pkg.sv
// Shared types and default timing for the T-latch driver.
// Holds the phase FSM encoding and counter sizing helpers.
package t_latch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_t;

    localparam int DEF_DEPTH     = 4;
    localparam int DEF_SETUP_CYC = 1;
    localparam int DEF_EN_WIDTH  = 2;
    localparam int DEF_HOLD_CYC  = 1;
    localparam bit DEF_SKIP_NOP  = 1'b1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Bits needed to hold a down-count from n-1 to 0.
    function automatic int cnt_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/t_latch_driver_fifo.sv
// DEPTH x 1-bit FIFO holding target Q levels.
// Extra level bit keeps full and empty distinct.
module t_bit_fifo
    import t_latch_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     push_bit,
    input  logic                     pop,
    output logic                     head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // A full FIFO ignores pushes even when a pop frees a slot this cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);
    assign level = count;
    assign head  = mem[rd_ptr];

    // Storage needs no reset; occupancy tracking decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wr_ptr] <= push_bit;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/t_latch_driver.sv
// Drives T/En strobes so a downstream T latch follows a target bit stream.
// Tracks the latch's Q in q_model and only toggles when needed.
module t_latch_driver
    import t_latch_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int EN_WIDTH  = DEF_EN_WIDTH,
    parameter int HOLD_CYC  = DEF_HOLD_CYC,
    parameter bit SKIP_NOP  = DEF_SKIP_NOP
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic                   in_bit,
    output logic                   in_ready,
    input  logic                   sync_clr,
    output logic                   t_out,
    output logic                   en_out,
    output logic                   q_model,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(DEPTH):0] level
);

    localparam int MAXC = max3(SETUP_CYC, EN_WIDTH, HOLD_CYC);
    localparam int CW   = cnt_bits(MAXC);

    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EN_LD    = CW'(EN_WIDTH - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          t_next;

    // Flush wins over a same-cycle push.
    assign push     = in_valid & ~full & ~sync_clr;
    assign pop      = (state == ST_IDLE) & ~empty & ~sync_clr;
    assign t_next   = head ^ q_model;
    assign in_ready = rst_n & ~full;
    assign busy     = (state != ST_IDLE);

    t_bit_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (sync_clr),
        .push     (push),
        .push_bit (in_bit),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .level    (level)
    );

    // Phase sequencer; one shared down-counter times every phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            t_out   <= 1'b0;
            en_out  <= 1'b0;
            q_model <= 1'b0;
            done    <= 1'b0;
        end else if (sync_clr) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            t_out   <= 1'b0;
            en_out  <= 1'b0;
            q_model <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (pop) begin
                        if (!t_next && SKIP_NOP) begin
                            done <= 1'b1;
                        end else begin
                            t_out <= t_next;
                            cnt   <= SETUP_LD;
                            state <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    if (cnt == '0) begin
                        en_out  <= 1'b1;
                        q_model <= q_model ^ t_out;
                        cnt     <= EN_LD;
                        state   <= ST_STROBE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_STROBE: begin
                    if (cnt == '0) begin
                        en_out <= 1'b0;
                        cnt    <= HOLD_LD;
                        state  <= ST_HOLD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        t_out <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_t_latch_driver.sv
// Directed bench for t_latch_driver with a behavioural T latch.
// Second instance runs with SKIP_NOP disabled.
module tb_t_latch_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       sync_clr = 1'b0;
    logic       in_ready, t_out, en_out, q_model, busy, done;
    logic [2:0] level;

    logic       in_valid2 = 1'b0;
    logic       in_bit2 = 1'b0;
    logic       sync_clr2 = 1'b0;
    logic       in_ready2, t_out2, en_out2, q_model2, busy2, done2;
    logic [2:0] level2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    t_latch_driver u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready), .sync_clr(sync_clr), .t_out(t_out),
        .en_out(en_out), .q_model(q_model), .busy(busy), .done(done),
        .level(level)
    );

    t_latch_driver #(.SKIP_NOP(1'b0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_bit(in_bit2),
        .in_ready(in_ready2), .sync_clr(sync_clr2), .t_out(t_out2),
        .en_out(en_out2), .q_model(q_model2), .busy(busy2), .done(done2),
        .level(level2)
    );

    // Behavioural T latch: toggles once per strobe when T is high.
    logic q_lat, en_lp;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_lat <= 1'b0;
            en_lp <= 1'b0;
        end else begin
            if (sync_clr) q_lat <= 1'b0;
            else if (en_out && !en_lp && t_out) q_lat <= ~q_lat;
            en_lp <= en_out;
        end
    end

    // Strobe monitor.
    int   rises = 0, en_cyc = 0, dones = 0, tchg = 0;
    int   width_cur = 0, last_width = 0;
    logic tpre = 1'b0, thold = 1'b0, en_p = 1'b0, t_p = 1'b0;
    always @(negedge clk) begin
        if (en_out && !en_p) begin
            rises++;
            tpre = t_p;
            width_cur = 1;
        end else if (en_out) begin
            width_cur++;
        end
        if (!en_out && en_p) begin
            last_width = width_cur;
            thold = t_out;
        end
        if (en_out && en_p && (t_out != t_p)) tchg++;
        if (en_out) en_cyc++;
        if (done) dones++;
        en_p = en_out;
        t_p  = t_out;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic b);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_bit = b;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("push_to", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        sync_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || level != 0) && n < 60);
        check("idle_to", 32'(busy || level != 0), 0);
        @(posedge clk);
        sample();
    endtask

    int r0, e0, d0, n, e2c, t2h;

    initial begin
        // Reset state
        #12;
        check("rst_en", 32'(en_out), 0);
        check("rst_t", 32'(t_out), 0);
        check("rst_q", 32'(q_model), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_lvl", 32'(level), 0);
        @(negedge clk);
        rst_n = 1'b1;
        sample();
        check("rst_rdy", 32'(in_ready), 1);

        // Single target 1
        r0 = rises; e0 = en_cyc; d0 = dones;
        push(1'b1);
        wait_idle();
        check("a_rises", rises - r0, 1);
        check("a_encyc", en_cyc - e0, 2);
        check("a_width", last_width, 2);
        check("a_dones", dones - d0, 1);
        check("a_tpre", 32'(tpre), 1);
        check("a_thold", 32'(thold), 1);
        check("a_tidle", 32'(t_out), 0);
        check("a_q", 32'(q_model), 1);
        check("a_lat", 32'(q_lat), 32'(q_model));

        // 1,1,0,0 back-to-back
        do_reset();
        r0 = rises; e0 = en_cyc; d0 = dones;
        push(1'b1); push(1'b1); push(1'b0); push(1'b0);
        wait_idle();
        check("b_rises", rises - r0, 2);
        check("b_encyc", en_cyc - e0, 4);
        check("b_dones", dones - d0, 4);
        check("b_q", 32'(q_model), 0);
        check("b_lat", 32'(q_lat), 32'(q_model));

        // Fill while a strobe is in flight
        do_reset();
        r0 = rises;
        push(1'b1); push(1'b0); push(1'b1); push(1'b0); push(1'b1);
        sample();
        check("c_lvl4", 32'(level), 4);
        check("c_rdy0", 32'(in_ready), 0);
        in_valid = 1'b1;
        in_bit = 1'b0;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("c_held", 32'(n > 0), 1);
        check("c_lvl3", 32'(level), 3);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sample();
        check("c_lvl4b", 32'(level), 4);
        wait_idle();
        check("c_rises", rises - r0, 6);
        check("c_q", 32'(q_model), 0);
        check("c_lat", 32'(q_lat), 32'(q_model));

        // Push and pop together at level 2
        do_reset();
        push(1'b1); push(1'b0); push(1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(!busy && level == 2) && n < 20);
        check("d_pre", 32'(level), 2);
        in_valid = 1'b1;
        in_bit = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sample();
        check("d_lvl2", 32'(level), 2);
        wait_idle();
        check("d_q", 32'(q_model), 1);
        check("d_lat", 32'(q_lat), 32'(q_model));

        // Async reset mid-strobe
        do_reset();
        push(1'b1); push(1'b0); push(1'b1);
        n = 0;
        while (!en_out && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("e_en_pre", 32'(en_out), 1);
        check("e_q_pre", 32'(q_model), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("e_en", 32'(en_out), 0);
        check("e_q", 32'(q_model), 0);
        check("e_lvl", 32'(level), 0);
        @(negedge clk);
        rst_n = 1'b1;
        sample();
        check("e_rdy", 32'(in_ready), 1);
        check("e_lat", 32'(q_lat), 32'(q_model));

        // sync_clr with three queued targets
        do_reset();
        push(1'b1); push(1'b1); push(1'b0); push(1'b1);
        sample();
        check("f_lvl3", 32'(level), 3);
        sync_clr = 1'b1;
        in_valid = 1'b1;
        in_bit = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        sync_clr = 1'b0;
        in_valid = 1'b0;
        check("f_lvl", 32'(level), 0);
        check("f_q", 32'(q_model), 0);
        check("f_en", 32'(en_out), 0);
        check("f_t", 32'(t_out), 0);
        check("f_busy", 32'(busy), 0);
        r0 = rises;
        repeat (20) @(negedge clk);
        #1;
        check("f_nostrb", rises - r0, 0);
        check("f_lvl_end", 32'(level), 0);
        check("f_lat", 32'(q_lat), 32'(q_model));

        // SKIP_NOP=0: target equal to q_model still strobes
        @(negedge clk);
        in_valid2 = 1'b1;
        in_bit2 = 1'b0;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        n = 0; e2c = 0; t2h = 0;
        do begin
            @(negedge clk);
            n++;
            if (en_out2) e2c++;
            if (en_out2 && t_out2) t2h++;
        end while (!done2 && n < 30);
        check("g_done", 32'(done2), 1);
        check("g_encyc", e2c, 2);
        check("g_thigh", t2h, 0);
        check("g_q", 32'(q_model2), 0);
        check("g_lvl", 32'(level2), 0);

        check("t_stable", tchg, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
